// File: rtl/loop_slot_scheduler.sv
// Frame-rate scheduler that shares the single Ram2Ddr port among the looper banks.
// Each frame tick gets one timed zero/write/read/skip slot per bank, then a mixer handoff.
`timescale 1ns/1ps
module loop_slot_scheduler #(
   parameter int NBANKS     = 8,
   parameter int ADDR_W     = 23,
   parameter int TICK_DIV   = 2268,
   parameter int ACC_CYC    = 26,
   parameter int MAX_BLOCKS = 8000000
) (
   input  logic                      clk_100MHz,
   input  logic                      rstn,
   input  logic [NBANKS-1:0]         playing,
   input  logic [NBANKS-1:0]         recording,
   input  logic                      delete,
   input  logic [$clog2(NBANKS)-1:0] delete_bank,
   input  logic [ADDR_W-1:0]         max_block,
   output logic                      ram_cen,
   output logic                      ram_oen,
   output logic                      ram_wen,
   output logic                      write_zero,
   output logic                      get_data,
   output logic                      data_ready,
   output logic                      mix_data,
   output logic                      delete_clear,
   output logic [ADDR_W-1:0]         block_addr,
   output logic [$clog2(NBANKS)-1:0] bank,
   output logic                      overrun
);
   localparam int BANK_W = $clog2(NBANKS);
   localparam int CNT_W  = $clog2(TICK_DIV);
   localparam int ACC_W  = $clog2(ACC_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SETUP, S_ACCESS, S_RECOVER, S_DONE} state_t;
   typedef enum logic [1:0] {K_READ, K_WRITE, K_ZERO} kind_t;

   state_t              state, state_d;
   kind_t               kind, kind_d;
   logic [CNT_W-1:0]    tick_cnt;
   logic                tick;
   logic [ACC_W-1:0]    acc_cnt, acc_cnt_d;
   logic [NBANKS-1:0]   play_f, play_f_d, rec_f, rec_f_d;
   logic                del_f, del_f_d;
   logic [BANK_W-1:0]   del_bank_f, del_bank_f_d, bank_d;
   logic [ADDR_W-1:0]   block_d, blk_next;
   logic                cen_d, oen_d, wen_d, wz_d;
   logic                get_data_d, data_ready_d, mix_d, dclr_d, overrun_d;
   logic                advance;

   assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk_100MHz or negedge rstn) begin
      if (!rstn) tick_cnt <= '0;
      else       tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
   end

   // Block address the frame will move to; an idle looper parks at block 0.
   always_comb begin
      blk_next = block_addr + ADDR_W'(1);
      if (!(|play_f) && !(|rec_f) && !del_f)
         blk_next = '0;
      else if ((max_block != '0) && (block_addr == max_block - ADDR_W'(1)))
         blk_next = '0;
      else if ((max_block == '0) && (block_addr == ADDR_W'(MAX_BLOCKS - 1)))
         blk_next = '0;
   end

   always_comb begin
      state_d      = state;
      kind_d       = kind;
      bank_d       = bank;
      acc_cnt_d    = acc_cnt;
      play_f_d     = play_f;
      rec_f_d      = rec_f;
      del_f_d      = del_f;
      del_bank_f_d = del_bank_f;
      block_d      = block_addr;
      cen_d        = 1'b1;
      oen_d        = 1'b1;
      wen_d        = 1'b1;
      wz_d         = 1'b0;
      get_data_d   = 1'b0;
      data_ready_d = 1'b0;
      mix_d        = 1'b0;
      dclr_d       = 1'b0;
      overrun_d    = tick && (state != S_IDLE);
      advance      = 1'b0;
      case (state)
         S_IDLE: if (tick) begin
            state_d    = S_LATCH;
            get_data_d = 1'b1;
            bank_d     = '0;
         end
         S_LATCH: begin
            play_f_d     = playing;
            rec_f_d      = recording;
            del_f_d      = delete;
            del_bank_f_d = delete_bank;
            state_d      = S_SETUP;
         end
         S_SETUP: begin
            acc_cnt_d = '0;
            state_d   = S_ACCESS;
            cen_d     = 1'b0;
            if (del_f && (del_bank_f == bank)) begin
               kind_d = K_ZERO;
               wen_d  = 1'b0;
               wz_d   = 1'b1;
            end else if (rec_f[bank]) begin
               kind_d = K_WRITE;
               wen_d  = 1'b0;
            end else if (play_f[bank]) begin
               kind_d = K_READ;
               oen_d  = 1'b0;
            end else begin
               cen_d   = 1'b1;
               advance = 1'b1;
            end
         end
         S_ACCESS: begin
            if (acc_cnt == ACC_W'(ACC_CYC - 1)) begin
               state_d      = S_RECOVER;
               data_ready_d = (kind == K_READ);
            end else begin
               acc_cnt_d = acc_cnt + ACC_W'(1);
               cen_d     = 1'b0;
               oen_d     = (kind != K_READ);
               wen_d     = (kind == K_READ);
               wz_d      = (kind == K_ZERO);
            end
         end
         S_RECOVER: advance = 1'b1;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      // Shared by skipped slots and RECOVER: next bank, or close the frame.
      if (advance) begin
         if (bank == BANK_W'(NBANKS - 1)) begin
            state_d = S_DONE;
            mix_d   = 1'b1;
            block_d = blk_next;
            dclr_d  = del_f && (blk_next == '0);
         end else begin
            state_d = S_SETUP;
            bank_d  = bank + BANK_W'(1);
         end
      end
   end

   always_ff @(posedge clk_100MHz or negedge rstn) begin
      if (!rstn) begin
         state        <= S_IDLE;
         kind         <= K_READ;
         bank         <= '0;
         acc_cnt      <= '0;
         play_f       <= '0;
         rec_f        <= '0;
         del_f        <= 1'b0;
         del_bank_f   <= '0;
         block_addr   <= '0;
         ram_cen      <= 1'b1;
         ram_oen      <= 1'b1;
         ram_wen      <= 1'b1;
         write_zero   <= 1'b0;
         get_data     <= 1'b0;
         data_ready   <= 1'b0;
         mix_data     <= 1'b0;
         delete_clear <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state        <= state_d;
         kind         <= kind_d;
         bank         <= bank_d;
         acc_cnt      <= acc_cnt_d;
         play_f       <= play_f_d;
         rec_f        <= rec_f_d;
         del_f        <= del_f_d;
         del_bank_f   <= del_bank_f_d;
         block_addr   <= block_d;
         ram_cen      <= cen_d;
         ram_oen      <= oen_d;
         ram_wen      <= wen_d;
         write_zero   <= wz_d;
         get_data     <= get_data_d;
         data_ready   <= data_ready_d;
         mix_data     <= mix_d;
         delete_clear <= dclr_d;
         overrun      <= overrun_d;
      end
   end
endmodule

// File: doc/loop_slot_scheduler.md
# loop_slot_scheduler

Sample-rate scheduler that shares the single SRAM-style port of `Ram2Ddr` among the eight looper banks. On every 44.1 kHz frame tick it walks banks 0–7 and issues one timed access per bank:

- zero-write for a bank being deleted,
- sample write for a recording bank,
- read for a playing bank,
- skip otherwise.

It then advances the shared block address and tells the mixer the frame is complete. It sits between `loop_ctrl` (bank state) and `Ram2Ddr`/mixer, replacing ad-hoc strobe generation with one deterministic frame schedule.

## Interface
- `NBANKS`, 8, number of banks; bank index is 3 bits.
- `ADDR_W`, 23, block address width.
- `TICK_DIV`, 2268, `clk_100MHz` cycles per frame (100 MHz / 44.1 kHz, rounded).
- `ACC_CYC`, 26, cycles `ram_cen` is held low per access (≥ 210 ns at 100 MHz).
- `MAX_BLOCKS`, 8000000, wrap limit used when no loop length is set.

Ports:
- `clk_100MHz`  in  1  system clock; all logic on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `playing`  in  8  per-bank play enable from loop_ctrl.
- `recording`  in  8  per-bank record enable.
- `delete`  in  1  delete request level; held until `delete_clear`.
- `delete_bank`  in  3  bank to zero.
- `max_block`  in  23  loop length in blocks; 0 = not yet set.
- `ram_cen`, `ram_oen`, `ram_wen`  out  1 each  active-low SRAM strobes.
- `write_zero`  out  1  selects 16'h7FFF as write data.
- `get_data`  out  1  one-cycle pulse: latch ADC sample.
- `data_ready`  out  1  one-cycle pulse: read data for `bank` valid.
- `mix_data`  out  1  one-cycle pulse: frame complete.
- `delete_clear`  out  1  one-cycle pulse: delete sweep done.
- `block_addr`  out  23  current block.
- `bank`  out  3  bank of current slot.
- `overrun`  out  1  one-cycle pulse: tick arrived while frame busy.

## Operation
- **Tick counter.** Free-running counter 0..`TICK_DIV`-1. A tick occurs on wrap to 0.
- **States:** IDLE, LATCH, SETUP, ACCESS, RECOVER, DONE.
- **IDLE.** On tick, go to LATCH.
- **LATCH (1 cycle).**
  - Pulse `get_data`.
  - Snapshot `playing`, `recording`, `delete`, `delete_bank` into frame registers. Changes mid-frame take effect next frame.
  - Set `bank`=0.
- **SETUP (1 cycle).** Classify the bank, priority zero > write > read > skip:
  - zero: delete snapshot set and `delete_bank`==`bank`.
  - write: `recording[bank]`.
  - read: `playing[bank]`.
  - skip: none of the above. Skip increments `bank`, or goes to DONE after bank 7. A skipped bank consumes only this cycle.
- **ACCESS (`ACC_CYC` cycles).**
  - `ram_cen`=0.
  - Read: `ram_oen`=0.
  - Write or zero: `ram_wen`=0; zero also sets `write_zero`=1.
- **RECOVER (1 cycle).**
  - All strobes high; `write_zero`=0.
  - Pulse `data_ready` if the slot was a read.
  - Then go to SETUP with `bank`+1, or to DONE after bank 7.
- **DONE (1 cycle).** Pulse `mix_data`, update the block address, go to IDLE.
- **Block update:**
  - If no bank plays or records and delete is clear: `block_addr`←0.
  - Else, `block_addr`←0 when `max_block`≠0 and `block_addr`=`max_block`-1.
  - Else, `block_addr`←0 when `max_block`=0 and `block_addr`=`MAX_BLOCKS`-1.
  - Otherwise `block_addr`+1.
- **Delete completion.** If the delete snapshot is set and the block wrapped to 0 in DONE, pulse `delete_clear` in the same cycle.
- **Overrun.** A tick outside IDLE pulses `overrun` and is dropped; the current frame continues. This cannot occur with default parameters (worst case 8×28+3 = 227 cycles).
- **Reset.**
  - Strobes = 1; all pulses, `write_zero`, `block_addr`, `bank`, tick counter and frame registers = 0; state = IDLE.
  - Reset mid-access releases strobes asynchronously.

## Timing
- Tick at cycle T: `get_data` at T; bank 0 SETUP at T+1.
- Active slot at SETUP cycle S: strobes low S+1..S+`ACC_CYC`; RECOVER at S+`ACC_CYC`+1. `data_ready` asserts in the RECOVER cycle.
- `bank`, `block_addr`, `write_zero` are stable from SETUP through RECOVER of a slot.
- `ram_oen` and `ram_wen` are never low together; strobes are glitch-free registered outputs.
- `mix_data` follows the last slot by exactly 1 cycle. Block address changes only in DONE.

## Test plan
- **Reset/idle.** Assert `rstn`=0 mid-ACCESS → strobes high immediately, all outputs 0. With no banks active, tick at T → `get_data` at T, eight skips, `mix_data` at T+9, `block_addr` stays 0.
- **Single play.** `playing`=8'h08, `max_block`=0 → only bank 3 accesses. `ram_cen`/`ram_oen` low 26 cycles with `bank`=3; `data_ready` at T+31; `mix_data` at T+36; `block_addr` 0→1.
- **Record + play, loop wrap.** `recording[0]`, `playing[1]`, `max_block`=4 → bank 0 uses `wen`, bank 1 uses `oen`. `block_addr` sequence 0,1,2,3,0 over five frames.
- **Delete.** `delete`=1, `delete_bank`=5, `playing[5]`=1, `max_block`=2 → bank 5 does zero-writes with `write_zero`=1 for two frames, never reads. `delete_clear` pulses once, in the second DONE.
- **Mid-frame change.** Toggle `recording[2]` during bank 0 ACCESS → current frame unchanged; next frame bank 2 writes.
- **Overrun.** `TICK_DIV`=40 with `playing`=8'hFF → `overrun` pulses and the dropped tick starts no frame. Every started frame completes all 8 slots with correct strobe widths.
